// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the memory port arbiter: the instruction-fetch
// read channel and the data-stage read/write channel, each with a request
// handshake and a one-cycle response pulse.
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;

    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;

    // Pipeline side: issues requests, consumes responses.
    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data
    );

    // Arbiter side: accepts requests, produces responses.
    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data
// stage. Data normally wins; a pending fetch is forced through after
// STARVE_LIMIT consecutive data grants. Reads take one capture cycle and
// respond with a registered one-cycle pulse; writes complete in the
// accept cycle.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_port_arbiter_if.slave        bus,
    output logic                     write_enabled,
    output logic [31:0]              addr,
    output logic [31:0]              w_data,
    input  logic [31:0]              r_data,
    output logic                     misalign_err
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {IDLE, CAPTURE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             winner_d_reg, winner_d_next;   // 1 = data read in flight
    logic             mis_rd_reg, mis_rd_next;       // in-flight read was misaligned
    logic             if_resp_valid_reg, d_resp_valid_reg;
    logic [31:0]      if_resp_data_reg, d_resp_data_reg;
    logic             misalign_reg;

    logic             grant_d, grant_f, accept, mis, is_write;
    logic [31:0]      sel_addr;

    // Arbitration, memory-port drive and next-state decode.
    always_comb begin
        grant_d       = 1'b0;
        grant_f       = 1'b0;
        state_next    = IDLE;
        winner_d_next = winner_d_reg;
        mis_rd_next   = mis_rd_reg;
        cnt_next      = cnt_reg;

        if (!rst && state_reg == IDLE) begin
            grant_d = bus.d_req_valid && !(bus.if_req_valid && cnt_reg == LIMIT);
            grant_f = bus.if_req_valid && !grant_d;
        end

        accept   = grant_d || grant_f;
        sel_addr = grant_d ? bus.d_req_addr : bus.if_req_addr;
        mis      = accept && (sel_addr[1:0] != 2'b00);
        is_write = grant_d && bus.d_req_we;

        write_enabled = is_write && !mis;
        addr          = (accept && !mis) ? sel_addr : 32'd0;
        w_data        = write_enabled ? bus.d_req_wdata : 32'd0;

        // Reads (misaligned ones included) go through the capture cycle.
        if (accept && !is_write) begin
            state_next    = CAPTURE;
            winner_d_next = grant_d;
            mis_rd_next   = mis;
        end

        // Counter tracks data grants taken while fetch is waiting.
        if (!bus.if_req_valid || grant_f) begin
            cnt_next = '0;
        end else if (grant_d && cnt_reg != LIMIT) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign bus.d_req_ready   = grant_d;
    assign bus.if_req_ready  = grant_f;
    assign bus.if_resp_valid = if_resp_valid_reg;
    assign bus.if_resp_data  = if_resp_data_reg;
    assign bus.d_resp_valid  = d_resp_valid_reg;
    assign bus.d_resp_data   = d_resp_data_reg;
    assign misalign_err      = misalign_reg;

    // State, counter and response registers; capture r_data for the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            winner_d_reg      <= 1'b0;
            mis_rd_reg        <= 1'b0;
            if_resp_valid_reg <= 1'b0;
            d_resp_valid_reg  <= 1'b0;
            if_resp_data_reg  <= 32'd0;
            d_resp_data_reg   <= 32'd0;
            misalign_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            winner_d_reg      <= winner_d_next;
            mis_rd_reg        <= mis_rd_next;
            if_resp_valid_reg <= 1'b0;
            d_resp_valid_reg  <= 1'b0;
            if (mis) begin
                misalign_reg <= 1'b1;
            end
            if (state_reg == CAPTURE) begin
                if (winner_d_reg) begin
                    d_resp_valid_reg <= 1'b1;
                    d_resp_data_reg  <= mis_rd_reg ? 32'd0 : r_data;
                end else begin
                    if_resp_valid_reg <= 1'b1;
                    if_resp_data_reg  <= mis_rd_reg ? 32'd0 : r_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory
// (one-cycle read latency, write on the edge where write_enabled is high).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        write_enabled;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .write_enabled (write_enabled),
        .addr          (addr),
        .w_data        (w_data),
        .r_data        (r_data),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    // Memory model: 64 KB word array.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (write_enabled) mem[addr[15:2]] <= w_data;
        r_data <= mem[addr[15:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the bench is straight-line, but never let it hang.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    string exp_seq = "DDDDFDDDDF";
    logic [7:0] grants [$];
    int grant_cyc [$];

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        mem[32'h1000 >> 2] = 32'h24020005;
        r_data = 32'd0;

        rst = 1'b1;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h1000;
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1;
        bus.d_req_addr = 32'h2000; bus.d_req_wdata = 32'h1111_2222;
        cyc(); cyc();
        @(negedge clk);
        check("rst_if_ready", bus.if_req_ready, 0);
        check("rst_d_ready", bus.d_req_ready, 0);
        check("rst_we", write_enabled, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", w_data, 0);
        check("rst_if_resp_valid", bus.if_resp_valid, 0);
        check("rst_d_resp_valid", bus.d_resp_valid, 0);
        check("rst_if_resp_data", bus.if_resp_data, 0);
        check("rst_d_resp_data", bus.d_resp_data, 0);
        check("rst_misalign", misalign_err, 0);

        // Fetch read 0x1000.
        cyc();
        rst = 1'b0; bus.d_req_valid = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h1000;
        @(negedge clk);
        check("f1_ready_T", bus.if_req_ready, 1);
        check("f1_addr_T", addr, 32'h1000);
        check("f1_we_T", write_enabled, 0);
        cyc(); bus.if_req_valid = 1'b0;
        @(negedge clk);
        check("f1_ready_capture", bus.if_req_ready, 0);
        check("f1_resp_valid_T1", bus.if_resp_valid, 0);
        cyc();
        @(negedge clk);
        check("f1_resp_valid_T2", bus.if_resp_valid, 1);
        check("f1_resp_data_T2", bus.if_resp_data, 32'h24020005);
        check("f1_d_resp_valid", bus.d_resp_valid, 0);
        cyc();
        @(negedge clk);
        check("f1_resp_valid_T3", bus.if_resp_valid, 0);
        check("f1_resp_data_hold", bus.if_resp_data, 32'h24020005);

        // Data write 0x2000 then read back.
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1;
        bus.d_req_addr = 32'h2000; bus.d_req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("w_ready_T", bus.d_req_ready, 1);
        check("w_we_T", write_enabled, 1);
        check("w_addr_T", addr, 32'h2000);
        check("w_wdata_T", w_data, 32'hDEADBEEF);
        cyc(); bus.d_req_we = 1'b0;
        @(negedge clk);
        check("r_ready_T1", bus.d_req_ready, 1);
        check("r_we_T1", write_enabled, 0);
        check("r_addr_T1", addr, 32'h2000);
        cyc(); bus.d_req_valid = 1'b0;
        @(negedge clk);
        check("r_d_resp_valid_T2", bus.d_resp_valid, 0);
        check("w_no_resp", bus.d_resp_valid, 0);
        cyc();
        @(negedge clk);
        check("r_d_resp_valid_T3", bus.d_resp_valid, 1);
        check("r_d_resp_data_T3", bus.d_resp_data, 32'hDEADBEEF);
        check("r_if_resp_valid", bus.if_resp_valid, 0);

        // Starvation: both reads held high for 20 cycles.
        cyc();
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h1000;
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h2000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.if_req_ready && bus.d_req_ready)
                check("starve_both_ready", 2, 1);
            if (bus.d_req_ready) begin grants.push_back("D"); grant_cyc.push_back(c); end
            else if (bus.if_req_ready) begin grants.push_back("F"); grant_cyc.push_back(c); end
            cyc();
        end
        bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
        check("starve_grant_count", grants.size(), 10);
        for (int g = 0; g < grants.size() && g < 10; g++) begin
            logic [7:0] e;
            e = exp_seq[g];
            check($sformatf("starve_grant%0d", g), grants[g], e);
            check($sformatf("starve_cycle%0d", g), grant_cyc[g], 2 * g);
        end
        cyc(); cyc();

        // Misaligned data write.
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1;
        bus.d_req_addr = 32'h2002; bus.d_req_wdata = 32'h5555AAAA;
        @(negedge clk);
        check("mw_ready_T", bus.d_req_ready, 1);
        check("mw_we_T", write_enabled, 0);
        check("mw_addr_T", addr, 0);
        check("mw_misalign_T", misalign_err, 0);
        cyc(); bus.d_req_valid = 1'b0;
        @(negedge clk);
        check("mw_misalign_T1", misalign_err, 1);
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h1000;
        cyc(); bus.if_req_valid = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        check("mw_misalign_sticky", misalign_err, 1);

        // Fetch read interrupted by reset.
        cyc();
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h1000;
        @(negedge clk);
        check("rf_ready_T", bus.if_req_ready, 1);
        cyc(); bus.if_req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rf_rst_ready", bus.if_req_ready, 0);
        cyc(); rst = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h1000;
        @(negedge clk);
        check("rf_no_resp_T2", bus.if_resp_valid, 0);
        check("rf_resp_data_cleared", bus.if_resp_data, 0);
        check("rf_misalign_cleared", misalign_err, 0);
        check("rf_new_accept", bus.if_req_ready, 1);
        cyc(); bus.if_req_valid = 1'b0;
        cyc();
        @(negedge clk);
        check("rf_new_resp_valid", bus.if_resp_valid, 1);
        check("rf_new_resp_data", bus.if_resp_data, 32'h24020005);

        // Misaligned fetch read returns zero.
        cyc();
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h1001;
        @(negedge clk);
        check("mf_ready_T", bus.if_req_ready, 1);
        check("mf_addr_T", addr, 0);
        cyc(); bus.if_req_valid = 1'b0;
        cyc();
        @(negedge clk);
        check("mf_resp_valid_T2", bus.if_resp_valid, 1);
        check("mf_resp_data_T2", bus.if_resp_data, 0);
        check("mf_misalign", misalign_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
